// File: rtl/morse_player_pkg.sv
// Shared Morse timing constants, codeword field positions and FSM state encoding.
// Pure definitions: no logic, no latency.
// No flow control of its own; imported by the player and its timer.
package morse_player_pkg;

  // Durations in Morse time units
  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] ELEM_GAP_UNITS = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

  // Codeword layout: [15:12] element count, [11:0] elements MSB first (1=dash)
  localparam int CNT_MSB   = 15;
  localparam int CNT_LSB   = 12;
  localparam int ELEM_MSB  = 11;
  localparam int MAX_ELEMS = 12;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_SPACE    = 3'd2,
    S_CHAR_GAP = 3'd3,
    S_WORD_GAP = 3'd4
  } state_e;

  // Counts above the element field width are played as a full field
  function automatic logic [3:0] clamp_count(input logic [3:0] cnt);
    if (cnt > 4'(MAX_ELEMS)) begin
      return 4'(MAX_ELEMS);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler emitting a one-cycle unit_tick_o every UNIT_CYCLES clocks.
// Tick is a decode of the count register; restart_i zeroes the count on the next edge.
// No backpressure: free-running, only restart_i alters its phase.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_l,
  input  logic restart_i,
  output logic unit_tick_o
);

  localparam int             CW   = $clog2(UNIT_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..UNIT_CYCLES-1, wrapping, and realign to 0 whenever the player changes state
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign unit_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/morse_player.sv
// Plays one Morse codeword per character as timed on/off keying on morse_out.
// morse_out changes on the accept edge; done pulses on the first IDLE cycle after the trailing gap.
// code_ready is high only in IDLE, so the producer stalls for the whole character.
module morse_player #(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [DATA_WIDTH-1:0] code_in,
  input  logic                  code_valid,
  output logic                  code_ready,
  output logic                  morse_out,
  output logic                  busy,
  output logic                  done
);

  import morse_player_pkg::*;

  state_e      state_q;
  logic [11:0] elems_q;     // remaining elements, current one at the MSB
  logic [3:0]  nelem_q;     // clamped element count of the word in flight
  logic [3:0]  idx_q;       // index of the element being played
  logic [2:0]  units_q;     // whole units already spent in the current state
  logic        morse_q;
  logic        done_q;

  logic        unit_tick;
  logic        unit_done;
  logic        accept;
  logic        restart;
  logic [2:0]  need_units;
  logic [3:0]  word_cnt;

  assign word_cnt = clamp_count(code_in[CNT_MSB:CNT_LSB]);
  assign accept   = code_valid && (state_q == S_IDLE);

  // Length of the current state in units
  always_comb begin
    need_units = DOT_UNITS;
    case (state_q)
      S_MARK:     need_units = elems_q[ELEM_MSB] ? DASH_UNITS : DOT_UNITS;
      S_SPACE:    need_units = ELEM_GAP_UNITS;
      S_CHAR_GAP: need_units = CHAR_GAP_UNITS;
      S_WORD_GAP: need_units = WORD_GAP_UNITS;
      default:    need_units = DOT_UNITS;
    endcase
  end

  // Every state change is either an accept or the end of a timed state
  assign unit_done = (state_q != S_IDLE) && unit_tick && (units_q == need_units - 3'd1);
  assign restart   = accept || unit_done;

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst_l       (rst_l),
    .restart_i   (restart),
    .unit_tick_o (unit_tick)
  );

  // Player FSM: outputs are registered on the same edge as the state they belong to
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      elems_q <= '0;
      nelem_q <= '0;
      idx_q   <= '0;
      units_q <= '0;
      morse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            elems_q <= code_in[ELEM_MSB:0];
            nelem_q <= word_cnt;
            idx_q   <= '0;
            units_q <= '0;
            if (word_cnt != 4'd0) begin
              state_q <= S_MARK;
              morse_q <= 1'b1;
            end else begin
              state_q <= S_WORD_GAP;
              morse_q <= 1'b0;
            end
          end
        end
        S_MARK: begin
          if (unit_done) begin
            units_q <= '0;
            morse_q <= 1'b0;
            if (idx_q < nelem_q - 4'd1) begin
              state_q <= S_SPACE;
              idx_q   <= idx_q + 4'd1;
              elems_q <= elems_q << 1;
            end else begin
              state_q <= S_CHAR_GAP;
            end
          end else if (unit_tick) begin
            units_q <= units_q + 3'd1;
          end
        end
        S_SPACE: begin
          if (unit_done) begin
            units_q <= '0;
            morse_q <= 1'b1;
            state_q <= S_MARK;
          end else if (unit_tick) begin
            units_q <= units_q + 3'd1;
          end
        end
        S_CHAR_GAP, S_WORD_GAP: begin
          if (unit_done) begin
            units_q <= '0;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (unit_tick) begin
            units_q <= units_q + 3'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          morse_q <= 1'b0;
        end
      endcase
    end
  end

  assign code_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign morse_out  = morse_q;
  assign done       = done_q;

endmodule

// File: tb/tb_morse_player.sv
// Randomized and directed bench for morse_player against a unit-level waveform model.
// Samples on the falling edge; sample k after the accept edge is the value "at T0+k".
// Drives code_valid noise while busy to show it is ignored.
module tb_morse_player;

  localparam int U = 4;

  logic        clk;
  logic        rst_l;
  logic [15:0] code_in;
  logic        code_valid;
  logic        code_ready;
  logic        morse_out;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  bit exp_q[$];

  morse_player #(
    .UNIT_CYCLES (U),
    .DATA_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .morse_out  (morse_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected morse_out trace, one entry per clock, starting the cycle after accept
  function automatic void build_exp(input logic [15:0] w);
    int n;
    exp_q.delete();
    n = int'(w[15:12]);
    if (n > 12) n = 12;
    if (n == 0) begin
      repeat (7 * U) exp_q.push_back(1'b0);
    end else begin
      for (int i = 0; i < n; i++) begin
        repeat ((w[11 - i] ? 3 : 1) * U) exp_q.push_back(1'b1);
        if (i < n - 1) repeat (U) exp_q.push_back(1'b0);
      end
      repeat (3 * U) exp_q.push_back(1'b0);
    end
  endfunction

  // Called just after a falling edge with code_ready expected high; returns likewise
  task automatic send_and_check(input string tag, input logic [15:0] w,
                                input bit keep_valid, input logic [15:0] next_w);
    int len, wave_bad, busy_bad, rdy_bad, done_bad;
    build_exp(w);
    len = exp_q.size();
    wave_bad = 0; busy_bad = 0; rdy_bad = 0; done_bad = 0;
    check({tag, "_ready_before"}, code_ready, 1);
    code_in    = w;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    if (keep_valid) code_in = next_w;
    else            code_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (morse_out !== exp_q[i]) wave_bad++;
      if (busy !== 1'b1)          busy_bad++;
      if (code_ready !== 1'b0)    rdy_bad++;
      if (done !== 1'b0)          done_bad++;
      if (!keep_valid) begin
        if (i < len - 1) begin
          code_valid = 1'($urandom_range(0, 1));
          code_in    = 16'($urandom);
        end else begin
          code_valid = 1'b0;
        end
      end
    end
    check({tag, "_wave_errs"}, wave_bad, 0);
    check({tag, "_busy_errs"}, busy_bad, 0);
    check({tag, "_ready_errs"}, rdy_bad, 0);
    check({tag, "_early_done"}, done_bad, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_ready_at_done"}, code_ready, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_out_at_done"}, morse_out, 0);
  endtask

  task automatic idle_cycles(input int k);
    int bad;
    bad = 0;
    code_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (code_ready !== 1'b1 || morse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_errs", bad, 0);
  endtask

  initial begin
    logic [15:0] w;
    tests_run    = 0;
    tests_failed = 0;
    rst_l      = 1'b0;
    code_valid = 1'b0;
    code_in    = 16'h0000;
    #3;
    check("rst_morse_out", morse_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", code_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    // Directed characters
    send_and_check("E", 16'h1000, 1'b0, 16'h0);
    idle_cycles(3);
    send_and_check("A", 16'h2400, 1'b0, 16'h0);
    idle_cycles(2);
    send_and_check("space", 16'h0000, 1'b0, 16'h0);
    idle_cycles(1);
    send_and_check("clamp", 16'hF000, 1'b0, 16'h0);
    idle_cycles(2);

    // Back-to-back with code_valid held: second word accepted on the done cycle
    send_and_check("b2b_T", 16'h1800, 1'b1, 16'h1000);
    send_and_check("b2b_E", 16'h1000, 1'b0, 16'h0);
    idle_cycles(2);

    // Random codewords, count field spanning 0..15
    for (int r = 0; r < 12; r++) begin
      w = 16'($urandom);
      if (r % 4 == 0) w[15:12] = 4'(12 + (r / 4));
      send_and_check($sformatf("rnd%0d", r), w, 1'b0, 16'h0);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a dash abandons the character
    code_in    = 16'h1800;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_dash_out", morse_out, 1);
    rst_l = 1'b0;
    #1;
    check("arst_morse_out", morse_out, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", code_ready, 1);
    #2;
    rst_l = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    send_and_check("post_rst_E", 16'h1000, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
